alu_rr_arbiter: RTL and testbench

//  Shares one combinational ALU instance (8-bit operands, 4-bit op select, result + carry_out) between two requesters.
//  - Round-robin grant, operand capture, single-cycle execute, registered response with valid/ready back-pressure.
//  - Sits between two datapath masters and the shared ALU; the only path by which either master reaches the ALU.
//

---
 rtl/alu_rr_arbiter_pkg.sv | 67 ++++++
 rtl/alu_rr_arbiter_if.sv | 30 +++
 rtl/alu_rr_arbiter_grant.sv | 27 ++
 rtl/alu_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared types, widths and the combinational ALU function for the ALU arbiter.
// Latency: n/a (declarations only; alu_eval is purely combinational).
// Backpressure: n/a.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ALU_W   = 8;
  localparam int ALU_OPW = 4;
  localparam int N_REQ   = 2;

  // Operation encodings understood by the shared ALU
  localparam logic [ALU_OPW-1:0] OP_ADD   = 4'h0;
  localparam logic [ALU_OPW-1:0] OP_SUB   = 4'h1;  // carry = 1 when no borrow
  localparam logic [ALU_OPW-1:0] OP_AND   = 4'h2;
  localparam logic [ALU_OPW-1:0] OP_OR    = 4'h3;
  localparam logic [ALU_OPW-1:0] OP_XOR   = 4'h4;
  localparam logic [ALU_OPW-1:0] OP_SHL   = 4'h5;  // carry = bit shifted out
  localparam logic [ALU_OPW-1:0] OP_SHR   = 4'h6;  // carry = bit shifted out
  localparam logic [ALU_OPW-1:0] OP_PASSB = 4'h7;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             carry;
  } alu_out_t;

  // The shared ALU; unused op codes yield zero result and zero carry
  function automatic alu_out_t alu_eval(input logic [ALU_W-1:0]   a,
                                        input logic [ALU_W-1:0]   b,
                                        input logic [ALU_OPW-1:0] op);
    logic [ALU_W:0] sum;
    alu_out_t       r;
    r   = '0;
    sum = '0;
    case (op)
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        r.result = sum[ALU_W-1:0];
        r.carry  = sum[ALU_W];
      end
      OP_SUB: begin
        sum      = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
        r.result = sum[ALU_W-1:0];
        r.carry  = sum[ALU_W];
      end
      OP_AND:   r.result = a & b;
      OP_OR:    r.result = a | b;
      OP_XOR:   r.result = a ^ b;
      OP_SHL: begin
        r.result = {a[ALU_W-2:0], 1'b0};
        r.carry  = a[ALU_W-1];
      end
      OP_SHR: begin
        r.result = {1'b0, a[ALU_W-1:1]};
        r.carry  = a[0];
      end
      OP_PASSB: r.result = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between the two datapath masters and the ALU arbiter.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready for the response.
interface alu_rr_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = ALU_OPW
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0][OPW-1:0]   req_op;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic                        rsp_id;
  logic [WIDTH-1:0]            rsp_result;
  logic                        rsp_carry;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
  );
endinterface

// File: rtl/alu_rr_arbiter_grant.sv
// Round-robin pick between two requesters: the one that did not win last time wins a tie.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is used.
module alu_rr_grant
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid,
  input  logic             last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_id,
  output logic             gnt_vld
);

  // Tie goes to the requester that was not served last
  always_comb begin
    gnt_id  = 1'b0;
    gnt_vld = |req_valid;
    case (req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
    gnt = gnt_vld ? (2'b01 << gnt_id) : 2'b00;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU between two requesters; grant counters built only with ALU_ARB_STATS_EN.
// Latency: accept -> EXEC -> response registered; rsp_valid visible two edges after the accept cycle.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready, no new grant meanwhile.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
)(
  input  logic            clk,
  input  logic            rst_n,
  alu_rr_arbiter_if.slave bus,
  output logic [CNTW-1:0] grant_cnt0,
  output logic [CNTW-1:0] grant_cnt1
);

  if (WIDTH != ALU_W) begin : g_bad_width
    $error("alu_rr_arbiter: WIDTH must be %0d", ALU_W);
  end
  if (OPW != ALU_OPW) begin : g_bad_opw
    $error("alu_rr_arbiter: OPW must be %0d", ALU_OPW);
  end

  arb_state_t       state_q, state_d;
  logic             last_grant_q;
  logic             gnt_id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic             rsp_valid_q, rsp_id_q, rsp_carry_q;
  logic [WIDTH-1:0] rsp_result_q;

  logic [N_REQ-1:0] gnt;
  logic             gnt_id, gnt_vld;
  logic [N_REQ-1:0] req_ready;
  logic             accept;
  alu_out_t         alu_out;

  alu_rr_grant u_grant (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_vld    (gnt_vld)
  );

  // The single ALU instance, fed only from the capture registers
  assign alu_out = alu_eval(a_q, b_q, op_q);

  // Next state and the IDLE-only combinational accept
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_ready = gnt;
          accept    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the winner's operands at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      gnt_id_q <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.req_a[gnt_id];
      b_q      <= bus.req_b[gnt_id];
      op_q     <= bus.req_op[gnt_id];
      gnt_id_q <= gnt_id;
    end
  end

  // Register the ALU output in EXEC; retire it and update fairness on rsp handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (state_q == EXEC) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= gnt_id_q;
      rsp_result_q <= alu_out.result;
      rsp_carry_q  <= alu_out.carry;
    end else if (state_q == RESP && bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
      last_grant_q <= rsp_id_q;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNTW-1:0] cnt0_q, cnt1_q;

  // Saturating per-requester grant counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (!gnt_id && cnt0_q != {CNTW{1'b1}}) cnt0_q <= cnt0_q + {{(CNTW-1){1'b0}}, 1'b1};
      if (gnt_id && cnt1_q != {CNTW{1'b1}})  cnt1_q <= cnt1_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: vector table, hand-written corner sequences, random ops vs a model.
// Latency checked: rsp_valid exactly two edges after the cycle req_ready is seen.
// Backpressure checked: response held stable and req_ready low while rsp_ready is low.
module tb_alu_rr_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gc0, gc1;

  int n_vec = 0;
  int n_err = 0;

  // Reference-model state: who was served last and how many grants each side got
  int m_last = 1;
  int m_cnt0 = 0;
  int m_cnt1 = 0;

  alu_rr_arbiter_if #(.WIDTH(8), .OPW(4)) bus ();

  alu_rr_arbiter #(.WIDTH(8), .OPW(4), .CNTW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] vld;
    logic [7:0] a0, b0;
    logic [3:0] op0;
    logic [7:0] a1, b1;
    logic [3:0] op1;
    int         hold;
    logic [1:0] rdy;
    logic       id;
    logic [7:0] res;
    logic       c;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain-arithmetic view of the ALU operations
  task automatic alu_ref(input int a, input int b, input int op, output int r, output int c);
    r = 0; c = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) / 256; end
      1: begin r = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 256; c = a / 128; end
      6: begin r = a / 2; c = a % 2; end
      7: r = b;
      default: begin r = 0; c = 0; end
    endcase
  endtask

  function automatic int exp_cnt(input int c);
`ifdef ALU_ARB_STATS_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // One complete operation; called just after a posedge with the DUT idle
  task automatic do_op(input logic [1:0] vld,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] op0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] op1,
                       input int hold, input logic [1:0] e_rdy, input logic e_id,
                       input logic [7:0] e_res, input logic e_c);
    bus.req_valid  = vld;
    bus.req_a[0]   = a0; bus.req_b[0] = b0; bus.req_op[0] = op0;
    bus.req_a[1]   = a1; bus.req_b[1] = b1; bus.req_op[1] = op1;
    bus.rsp_ready  = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'(e_rdy));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(e_id));
    chk("rsp_result", 32'(bus.rsp_result), 32'(e_res));
    chk("rsp_carry", 32'(bus.rsp_carry), 32'(e_c));
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_id", 32'(bus.rsp_id), 32'(e_id));
      chk("hold_result", 32'(bus.rsp_result), 32'(e_res));
      chk("hold_carry", 32'(bus.rsp_carry), 32'(e_c));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b00;
    chk("rsp_retire", 32'(bus.rsp_valid), 32'd0);
    m_last = e_id;
    if (e_id) m_cnt1++;
    else      m_cnt0++;
  endtask

  initial begin
    tbl[0] = '{2'b01, 8'h33, 8'hCC, 4'h0, 8'h00, 8'h00, 4'h0, 0, 2'b01, 1'b0, 8'hFF, 1'b0};
    tbl[1] = '{2'b10, 8'h00, 8'h00, 4'h0, 8'hFF, 8'h01, 4'h0, 0, 2'b10, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{2'b11, 8'h10, 8'h01, 4'h1, 8'h55, 8'h55, 4'h0, 1, 2'b01, 1'b0, 8'h0F, 1'b1};
    tbl[3] = '{2'b11, 8'h00, 8'h00, 4'h0, 8'h01, 8'h02, 4'h1, 0, 2'b10, 1'b1, 8'hFF, 1'b0};
    tbl[4] = '{2'b01, 8'hF0, 8'h3C, 4'h2, 8'h00, 8'h00, 4'h0, 2, 2'b01, 1'b0, 8'h30, 1'b0};
    tbl[5] = '{2'b10, 8'h00, 8'h00, 4'h0, 8'h81, 8'h00, 4'h5, 0, 2'b10, 1'b1, 8'h02, 1'b1};
    tbl[6] = '{2'b01, 8'h81, 8'h00, 4'h6, 8'h00, 8'h00, 4'h0, 0, 2'b01, 1'b0, 8'h40, 1'b1};
    tbl[7] = '{2'b10, 8'h00, 8'h00, 4'h0, 8'hF0, 8'h0F, 4'h4, 5, 2'b10, 1'b1, 8'hFF, 1'b0};
    tbl[8] = '{2'b11, 8'hA5, 8'h5A, 4'h3, 8'h12, 8'h34, 4'h0, 0, 2'b01, 1'b0, 8'hFF, 1'b0};

    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req_a[i] = '0; bus.req_b[i] = '0; bus.req_op[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("reset_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_cnt0", 32'(gc0), 32'd0);
    chk("reset_cnt1", 32'(gc1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle with nothing requested: no accept, no response
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("idle_req_ready", 32'(bus.req_ready), 32'd0);
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      do_op(tbl[i].vld, tbl[i].a0, tbl[i].b0, tbl[i].op0, tbl[i].a1, tbl[i].b1, tbl[i].op1,
            tbl[i].hold, tbl[i].rdy, tbl[i].id, tbl[i].res, tbl[i].c);
    chk("table_cnt0", 32'(gc0), 32'(exp_cnt(m_cnt0)));
    chk("table_cnt1", 32'(gc1), 32'(exp_cnt(m_cnt1)));

    // Reset while req0 is in EXEC: operation dropped, FSM back in IDLE
    bus.req_valid = 2'b01;
    bus.req_a[0] = 8'h33; bus.req_b[0] = 8'hCC; bus.req_op[0] = 4'h0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midexec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midexec_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("midexec_cnt0", 32'(gc0), 32'd0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midexec_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    m_last = 1; m_cnt0 = 0; m_cnt1 = 0;

    // Continuous dual requests after reset alternate 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ea, eb;
      ea = 8'(i * 16 + 1);
      eb = 8'(i * 16 + 2);
      do_op(2'b11, ea, 8'h01, 4'h0, eb, 8'h02, 4'h0, 0,
            (i % 2 == 0) ? 2'b01 : 2'b10, 1'(i % 2),
            (i % 2 == 0) ? 8'(ea + 8'h01) : 8'(eb + 8'h02), 1'b0);
    end

    // Grant counters: 3 x req0, 2 x req1 after a fresh reset
    reset_dut();
    for (int i = 0; i < 3; i++)
      do_op(2'b01, 8'h01, 8'h01, 4'h0, 8'h00, 8'h00, 4'h0, 0, 2'b01, 1'b0, 8'h02, 1'b0);
    for (int i = 0; i < 2; i++)
      do_op(2'b10, 8'h00, 8'h00, 4'h0, 8'h02, 8'h02, 4'h2, 0, 2'b10, 1'b1, 8'h02, 1'b0);
    chk("stats_cnt0", 32'(gc0), 32'(exp_cnt(3)));
    chk("stats_cnt1", 32'(gc1), 32'(exp_cnt(2)));

    // Random traffic checked against the model
    for (int i = 0; i < 60; i++) begin
      logic [1:0] vld;
      logic [7:0] a0, b0, a1, b1;
      logic [3:0] op0, op1;
      int g, r, c;
      vld = 2'($urandom_range(1, 3));
      a0 = 8'($urandom); b0 = 8'($urandom); op0 = 4'($urandom_range(0, 15));
      a1 = 8'($urandom); b1 = 8'($urandom); op1 = 4'($urandom_range(0, 15));
      if (vld == 2'b11) g = 1 - m_last;
      else              g = (vld == 2'b10) ? 1 : 0;
      if (g == 1) alu_ref(int'(a1), int'(b1), int'(op1), r, c);
      else        alu_ref(int'(a0), int'(b0), int'(op0), r, c);
      do_op(vld, a0, b0, op0, a1, b1, op1, int'($urandom_range(0, 2)),
            (g == 1) ? 2'b10 : 2'b01, 1'(g), 8'(r), 1'(c));
    end
    chk("random_cnt0", 32'(gc0), 32'(exp_cnt(m_cnt0)));
    chk("random_cnt1", 32'(gc1), 32'(exp_cnt(m_cnt1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
